msfsm_ring_mealy: RTL and testbench
===================================

// Module: msfsm_ring_mealy
// PURPOSE
//  Parametrised one-hot Mealy FSM for one ring of a multi-synchronous FSM (MSFSM) decomposition of a marked graph.
//  N_STATES places are chained in a cycle; leaving place i fires transition i, which is either an input event
//  (waits on ev_in[i]) or an output event (emits an ev_out[i] pulse). Every transition is gated by transition-barrier
//  (TB) inputs from sibling rings. Adds over the fixed-ring generation: a lap counter and illegal-state detection/recovery.
// PARAMETERS
//  N_STATES   5          places/transitions in the ring, >=2
//  INIT_STATE 0          place index held after reset
//  OUT_MASK   5'b00111   bit i=1: transition i is an output event; 0: input event
//  TB_W       3          TB inputs per transition
//  TB_MASK    all ones   [N_STATES*TB_W-1:0]; bit i*TB_W+k=1: barrier k of transition i is used
//  LAP_W      8          width of lap counter
//  STALL_MAX  255        watchdog threshold in cycles (only with MSFSM_WATCHDOG_EN)
// PORTS
//  clk        in   1                  single clock, rising edge
//  reset      in   1                  synchronous, active-high
//  ev_in      in   N_STATES           input-event strobes; bit i ignored when OUT_MASK[i]=1
//  tb_rdy     in   N_STATES*TB_W      barrier readiness = sibling place-marked signals
//  ev_out     out  N_STATES           Mealy output-event pulses; always 0 for input-event bits
//  place      out  N_STATES           one-hot marking (= state register), exported to sibling TBs
//  lap_cnt    out  LAP_W              completed ring laps
//  err_illegal out 1                  sticky, set on non-one-hot state
//  stall      out  1                  watchdog flag (tied 0 without MSFSM_WATCHDOG_EN)
// BEHAVIOUR
//  - Reset (priority over all): place=1<<INIT_STATE, lap_cnt=0, err_illegal=0, stall=0; ev_out=0 while reset=1.
//  - tb_ok[i] = &(tb_rdy[i*TB_W +: TB_W] | ~TB_MASK[i*TB_W +: TB_W]); all-zero mask slice => tb_ok=1.
//  - fire[i] = place[i] & tb_ok[i] & (OUT_MASK[i] | ev_in[i]); at most one bit of fire is set.
//  - ev_out[i] = fire[i] & OUT_MASK[i], combinational, same cycle as the enabling conditions; 0 latency.
//  - On fire[i]: next place = 1<<((i+1) mod N_STATES); otherwise hold. One transition per clock, at most.
//  - Firing from place N_STATES-1: lap_cnt+1, wraps modulo 2^LAP_W with no flag.
//  - Illegal state (place not one-hot, including all-zero): ev_out=0, fire suppressed, next place=1<<INIT_STATE,
//    err_illegal<=1 (cleared only by reset), lap_cnt holds.
//  - ev_in asserted in a place that does not own it: ignored, with no memory (level-sensitive, not latched).
//  - Reset mid-firing: reset wins; the transition is discarded and the ring restarts at INIT_STATE.
// CONFIGURATION
//  MSFSM_WATCHDOG_EN defined: stall_cnt counts cycles with fire==0 and clears on any fire or reset.
//    stall=1 while stall_cnt>=STALL_MAX; stall_cnt saturates at STALL_MAX. Observation only; no recovery action.
//  Undefined: no counter is built and stall is tied 1'b0.
// STRUCTURE
//  msfsm_pkg: onehot_ok() function, place-index-to-one-hot function, default LAP_W/TB_W constants.
//  Sub-module msfsm_tb_sync: per-transition masked barrier AND (TB_W in, 1 out), instantiated N_STATES times.
//  Top contains the state register, fire/next-state logic, lap counter, error flag and optional watchdog.
// TESTING  (defaults unless stated)
//  1. Reset=1 for 2 clk, then 0 -> place=5'b00001, ev_out=0, lap_cnt=0, err_illegal=0.
//  2. All tb_rdy=1, ev_in[4:3]=1 held -> ev_out pulses bits 0,1,2 on consecutive cycles; place cycles
//     00001->...->10000->00001; lap_cnt increments by 1 every 5 clk.
//  3. place=00001, tb_rdy[2:0]=3'b011 -> ev_out[0]=0 and place holds; setting tb_rdy[2]=1 fires in that same cycle.
//  4. LAP_W=2, run 4 laps -> lap_cnt reads 1,2,3,0.
//  5. Force state=5'b00110 -> next cycle place=00001, err_illegal=1; stays 1 until reset.
//  6. MSFSM_WATCHDOG_EN, STALL_MAX=4, ev_in=0 at place 3 -> stall=1 after 4 idle clk; ev_in[3]=1 -> stall=0 next clk.

Source files
------------

// File: rtl/msfsm_ring_mealy_pkg.sv
// Shared types, constants and one-hot helpers for the MSFSM ring.
package msfsm_ring_mealy_pkg;

    localparam int MSFSM_MAX_STATES = 32;
    localparam int MSFSM_DEF_LAP_W  = 8;
    localparam int MSFSM_DEF_TB_W   = 3;

    typedef enum logic [0:0] {
        RING_HEALTHY = 1'b0,
        RING_FAULTED = 1'b1
    } ring_health_e;

    // Zero is not one-hot; callers zero-extend narrower markings.
    function automatic logic onehot_ok(input logic [MSFSM_MAX_STATES-1:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [MSFSM_MAX_STATES-1:0] idx_to_onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/msfsm_ring_mealy_if.sv
// Event, barrier and status bundle between a ring and its environment.
interface msfsm_ring_mealy_if
    import msfsm_ring_mealy_pkg::*;
#(
    parameter int N_STATES = 5,
    parameter int TB_W     = MSFSM_DEF_TB_W,
    parameter int LAP_W    = MSFSM_DEF_LAP_W
);
    logic [N_STATES-1:0]      ev_in;
    logic [N_STATES*TB_W-1:0] tb_rdy;
    logic [N_STATES-1:0]      ev_out;
    logic [N_STATES-1:0]      place;
    logic [LAP_W-1:0]         lap_cnt;
    logic                     err_illegal;
    logic                     stall;

    modport master (
        output ev_in, tb_rdy,
        input  ev_out, place, lap_cnt, err_illegal, stall
    );

    modport slave (
        input  ev_in, tb_rdy,
        output ev_out, place, lap_cnt, err_illegal, stall
    );
endinterface

// File: rtl/msfsm_ring_mealy_tb_sync.sv
// Masked AND of one transition's barrier inputs; unused barriers read as ready.
module msfsm_tb_sync #(
    parameter int              TB_W = 3,
    parameter logic [TB_W-1:0] MASK = '1
) (
    input  logic [TB_W-1:0] i_rdy,
    output logic            o_ok
);
    assign o_ok = &(i_rdy | ~MASK);
endmodule

// File: rtl/msfsm_ring_mealy.sv
// One-hot Mealy ring of an MSFSM decomposition with lap counter and illegal-state recovery.
// Optional stall watchdog enabled by defining MSFSM_WATCHDOG_EN.
module msfsm_ring_mealy
    import msfsm_ring_mealy_pkg::*;
#(
    parameter int                       N_STATES   = 5,
    parameter int                       INIT_STATE = 0,
    parameter logic [N_STATES-1:0]      OUT_MASK   = 5'b00111,
    parameter int                       TB_W       = MSFSM_DEF_TB_W,
    parameter logic [N_STATES*TB_W-1:0] TB_MASK    = '1,
    parameter int                       LAP_W      = MSFSM_DEF_LAP_W,
    parameter int                       STALL_MAX  = 255
) (
    input  logic              clk,
    input  logic              reset,
    msfsm_ring_mealy_if.slave bus
);

    localparam logic [MSFSM_MAX_STATES-1:0] INIT_WIDE  = idx_to_onehot(INIT_STATE);
    localparam logic [N_STATES-1:0]         INIT_PLACE = INIT_WIDE[N_STATES-1:0];

    logic [N_STATES-1:0]         r_place;
    logic [LAP_W-1:0]            r_lap_cnt;
    ring_health_e                r_health;
    logic [N_STATES-1:0]         w_tb_ok;
    logic [N_STATES-1:0]         w_fire;
    logic [N_STATES-1:0]         w_next_place;
    logic [MSFSM_MAX_STATES-1:0] w_place_ext;
    logic                        w_legal;

    assign w_place_ext = {{(MSFSM_MAX_STATES-N_STATES){1'b0}}, r_place};
    assign w_legal     = onehot_ok(w_place_ext);

    for (genvar g = 0; g < N_STATES; g++) begin : g_sync
        msfsm_tb_sync #(
            .TB_W (TB_W),
            .MASK (TB_MASK[g*TB_W +: TB_W])
        ) u_sync (
            .i_rdy (bus.tb_rdy[g*TB_W +: TB_W]),
            .o_ok  (w_tb_ok[g])
        );
    end

    // A corrupted marking or an active reset must never emit an event.
    always_comb begin
        w_fire = '0;
        if (w_legal && !reset) begin
            w_fire = r_place & w_tb_ok & (OUT_MASK | bus.ev_in);
        end else begin
            w_fire = '0;
        end
    end

    // Fire moves the token one place round the ring.
    always_comb begin
        w_next_place = r_place;
        if (|w_fire) begin
            w_next_place = {r_place[N_STATES-2:0], r_place[N_STATES-1]};
        end else begin
            w_next_place = r_place;
        end
    end

    // Marking, lap count and ring health.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_place   <= INIT_PLACE;
            r_lap_cnt <= '0;
            r_health  <= RING_HEALTHY;
        end else if (!w_legal) begin
            r_place   <= INIT_PLACE;
            r_health  <= RING_FAULTED;
        end else begin
            r_place <= w_next_place;
            if (w_fire[N_STATES-1]) begin
                r_lap_cnt <= r_lap_cnt + 1'b1;
            end
        end
    end

`ifdef MSFSM_WATCHDOG_EN
    localparam int                 STALL_W   = $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    logic [STALL_W-1:0] r_stall_cnt;

    // Saturating count of consecutive cycles without a firing.
    always_ff @(posedge clk) begin
        if (reset || (|w_fire)) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt < STALL_LIM) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.stall = (r_stall_cnt >= STALL_LIM);
`else
    assign bus.stall = 1'b0;
`endif

    assign bus.ev_out      = w_fire & OUT_MASK;
    assign bus.place       = r_place;
    assign bus.lap_cnt     = r_lap_cnt;
    assign bus.err_illegal = (r_health == RING_FAULTED);

endmodule

// File: tb/tb_msfsm_ring_mealy.sv
// Directed bench for msfsm_ring_mealy: default ring plus a LAP_W=2 copy sharing stimulus.
module tb_msfsm_ring_mealy;

    localparam logic [4:0] OUT_MASK_E = 5'b00111;
`ifdef MSFSM_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk;
    logic        r_reset;
    logic [4:0]  r_ev_in;
    logic [14:0] r_tb_rdy;
    logic [7:0]  g_lap;
    int          checks;
    int          errors;

    msfsm_ring_mealy_if #(.N_STATES(5), .TB_W(3), .LAP_W(8)) bus0 ();
    msfsm_ring_mealy_if #(.N_STATES(5), .TB_W(3), .LAP_W(2)) bus1 ();

    assign bus0.ev_in  = r_ev_in;
    assign bus0.tb_rdy = r_tb_rdy;
    assign bus1.ev_in  = r_ev_in;
    assign bus1.tb_rdy = r_tb_rdy;

    msfsm_ring_mealy #(.LAP_W(8), .STALL_MAX(4)) dut (
        .clk   (clk),
        .reset (r_reset),
        .bus   (bus0)
    );

    msfsm_ring_mealy #(.LAP_W(2), .STALL_MAX(4)) dut_l2 (
        .clk   (clk),
        .reset (r_reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        r_reset  = 1'b1;
        r_ev_in  = 5'b00000;
        r_tb_rdy = '1;
        @(negedge clk); #1;
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL reset_evout: got %b expected %b", bus0.ev_out, 5'b00000); end
        @(negedge clk);
        r_tb_rdy = '0;
        r_reset  = 1'b0;
        #1;
        checks++;
        if (bus0.place !== 5'b00001) begin errors++; $display("FAIL reset_place: got %b expected %b", bus0.place, 5'b00001); end
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL reset_evout_idle: got %b expected %b", bus0.ev_out, 5'b00000); end
        checks++;
        if (bus0.lap_cnt !== 8'd0) begin errors++; $display("FAIL reset_lap: got %0d expected %0d", bus0.lap_cnt, 0); end
        checks++;
        if (bus0.err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", bus0.err_illegal, 1'b0); end
        checks++;
        if (bus0.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", bus0.stall, 1'b0); end
        g_lap = 8'd0;
    endtask

    task automatic test_ring_laps();
        logic [4:0] e_place;
        r_tb_rdy = '1;
        r_ev_in  = 5'b11000;
        #1;
        for (int k = 0; k < 20; k++) begin
            e_place = 5'b00001 << (k % 5);
            checks++;
            if (bus0.place !== e_place) begin errors++; $display("FAIL ring_place[%0d]: got %b expected %b", k, bus0.place, e_place); end
            checks++;
            if (bus0.ev_out !== (e_place & OUT_MASK_E)) begin errors++; $display("FAIL ring_evout[%0d]: got %b expected %b", k, bus0.ev_out, e_place & OUT_MASK_E); end
            checks++;
            if (bus0.lap_cnt !== g_lap) begin errors++; $display("FAIL ring_lap[%0d]: got %0d expected %0d", k, bus0.lap_cnt, g_lap); end
            checks++;
            if (bus1.lap_cnt !== g_lap[1:0]) begin errors++; $display("FAIL lap_wrap[%0d]: got %0d expected %0d", k, bus1.lap_cnt, g_lap[1:0]); end
            if ((k % 5) == 4) g_lap = g_lap + 8'd1;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_barrier();
        r_tb_rdy = 15'h7FFB;
        #1;
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL barrier_block_evout: got %b expected %b", bus0.ev_out, 5'b00000); end
        @(negedge clk); #1;
        checks++;
        if (bus0.place !== 5'b00001) begin errors++; $display("FAIL barrier_hold: got %b expected %b", bus0.place, 5'b00001); end
        r_tb_rdy = 15'h7FFF;
        #1;
        checks++;
        if (bus0.ev_out !== 5'b00001) begin errors++; $display("FAIL barrier_release_evout: got %b expected %b", bus0.ev_out, 5'b00001); end
        @(negedge clk);
        r_tb_rdy = '0;
        #1;
        checks++;
        if (bus0.place !== 5'b00010) begin errors++; $display("FAIL barrier_fired: got %b expected %b", bus0.place, 5'b00010); end
    endtask

    task automatic test_ignored_event();
        logic e_stall;
        r_ev_in  = 5'b10000;
        r_tb_rdy = '1;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (bus0.place !== 5'b01000) begin errors++; $display("FAIL ign_arrive: got %b expected %b", bus0.place, 5'b01000); end
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL ign_evout: got %b expected %b", bus0.ev_out, 5'b00000); end
        for (int j = 1; j <= 4; j++) begin
            if (j == 2) r_ev_in = 5'b00000;
            @(negedge clk); #1;
            e_stall = WD_EN && (j >= 4);
            checks++;
            if (bus0.place !== 5'b01000) begin errors++; $display("FAIL ign_hold[%0d]: got %b expected %b", j, bus0.place, 5'b01000); end
            checks++;
            if (bus0.stall !== e_stall) begin errors++; $display("FAIL stall[%0d]: got %b expected %b", j, bus0.stall, e_stall); end
        end
        r_ev_in = 5'b01000;
        #1;
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL input_evout: got %b expected %b", bus0.ev_out, 5'b00000); end
        @(negedge clk); #1;
        checks++;
        if (bus0.place !== 5'b10000) begin errors++; $display("FAIL input_fire: got %b expected %b", bus0.place, 5'b10000); end
        checks++;
        if (bus0.stall !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b expected %b", bus0.stall, 1'b0); end
        @(negedge clk); #1;
        checks++;
        if (bus0.place !== 5'b10000) begin errors++; $display("FAIL wait_p4: got %b expected %b", bus0.place, 5'b10000); end
        r_ev_in = 5'b10000;
        @(negedge clk);
        r_tb_rdy = '0;
        r_ev_in  = 5'b00000;
        #1;
        g_lap = g_lap + 8'd1;
        checks++;
        if (bus0.place !== 5'b00001) begin errors++; $display("FAIL p4_fire: got %b expected %b", bus0.place, 5'b00001); end
        checks++;
        if (bus0.lap_cnt !== g_lap) begin errors++; $display("FAIL p4_lap: got %0d expected %0d", bus0.lap_cnt, g_lap); end
    endtask

    task automatic test_illegal();
        r_tb_rdy = '1;
        r_ev_in  = '1;
        force dut.r_place = 5'b00110;
        #1;
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL illegal_evout: got %b expected %b", bus0.ev_out, 5'b00000); end
        @(posedge clk); #1;
        checks++;
        if (bus0.err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err_set: got %b expected %b", bus0.err_illegal, 1'b1); end
        release dut.r_place;
        r_tb_rdy = '0;
        r_ev_in  = '0;
        @(posedge clk); #1;
        checks++;
        if (bus0.place !== 5'b00001) begin errors++; $display("FAIL illegal_recover: got %b expected %b", bus0.place, 5'b00001); end
        checks++;
        if (bus0.lap_cnt !== g_lap) begin errors++; $display("FAIL illegal_lap_hold: got %0d expected %0d", bus0.lap_cnt, g_lap); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky: got %b expected %b", bus0.err_illegal, 1'b1); end
    endtask

    task automatic test_reset_mid_fire();
        @(negedge clk);
        r_tb_rdy = '1;
        #1;
        checks++;
        if (bus0.ev_out !== 5'b00001) begin errors++; $display("FAIL prefire_evout: got %b expected %b", bus0.ev_out, 5'b00001); end
        r_reset = 1'b1;
        #1;
        checks++;
        if (bus0.ev_out !== 5'b00000) begin errors++; $display("FAIL midreset_evout: got %b expected %b", bus0.ev_out, 5'b00000); end
        @(negedge clk); #1;
        checks++;
        if (bus0.place !== 5'b00001) begin errors++; $display("FAIL midreset_place: got %b expected %b", bus0.place, 5'b00001); end
        checks++;
        if (bus0.err_illegal !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected %b", bus0.err_illegal, 1'b0); end
        checks++;
        if (bus0.lap_cnt !== 8'd0) begin errors++; $display("FAIL midreset_lap: got %0d expected %0d", bus0.lap_cnt, 0); end
        checks++;
        if (bus1.lap_cnt !== 2'd0) begin errors++; $display("FAIL midreset_lap2: got %0d expected %0d", bus1.lap_cnt, 0); end
        r_tb_rdy = '0;
        r_reset  = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus0.place !== 5'b00001) begin errors++; $display("FAIL postreset_place: got %b expected %b", bus0.place, 5'b00001); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        g_lap  = 8'd0;
        test_reset();
        test_ring_laps();
        test_barrier();
        test_ignored_event();
        test_illegal();
        test_reset_mid_fire();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
